// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and default read latency.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StAck    = 2'd3
  } state_e;

  localparam int unsigned MemLatDefault = 1;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module arb_rr_pick (
  input  logic p0_req_i,
  input  logic p1_req_i,
  input  logic lastgnt_i,
  output logic valid_o,
  output logic gnt_o
);

  always_comb begin
    valid_o = p0_req_i | p1_req_i;
    if (p0_req_i && p1_req_i) begin
      gnt_o = ~lastgnt_i;
    end else begin
      gnt_o = p1_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin grant, one access per transaction, registered outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MEMLAT = MemLatDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [WIDTH-1:0] p0_adr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_ack,
  output logic [WIDTH-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_adr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_ack,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  // WAIT counts down to zero, so it is loaded with one less than the latency.
  localparam logic [2:0] WaitInit = 3'(MEMLAT - 1);

  state_e           state_q;
  logic             lastgnt_q, gnt_q, we_q;
  logic [2:0]       cnt_q;
  logic             mem_read_q, mem_write_q, busy_q;
  logic [1:0]       ack_q;
  logic [WIDTH-1:0] adr_q, wdata_q, rdata0_q, rdata1_q;

  logic             pick_valid, pick_gnt;
  logic             sel_we;
  logic [WIDTH-1:0] sel_adr, sel_wdata;

  arb_rr_pick u_pick (
    .p0_req_i  (p0_req),
    .p1_req_i  (p1_req),
    .lastgnt_i (lastgnt_q),
    .valid_o   (pick_valid),
    .gnt_o     (pick_gnt)
  );

  assign sel_we    = pick_gnt ? p1_we    : p0_we;
  assign sel_adr   = pick_gnt ? p1_adr   : p0_adr;
  assign sel_wdata = pick_gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lastgnt_q   <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack_q       <= '0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            gnt_q       <= pick_gnt;
            lastgnt_q   <= pick_gnt;
            we_q        <= sel_we;
            adr_q       <= sel_adr;
            wdata_q     <= sel_wdata;
            mem_read_q  <= ~sel_we;
            mem_write_q <= sel_we;
            busy_q      <= 1'b1;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (we_q) begin
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= StAck;
          end else begin
            cnt_q   <= WaitInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            if (gnt_q) begin
              rdata1_q <= mem_rdata;
            end else begin
              rdata0_q <= mem_rdata;
            end
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StAck: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiter instances (read latency 1 and 3) checked against a transaction-timeline model.
module tb_mem_arbiter;

  typedef struct packed {
    logic       ack0;
    logic       ack1;
    logic       rd;
    logic       wr;
    logic       busy;
    logic       wt;
    logic       rdv;
    logic       rdp;
    logic [7:0] rdd;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input int lane, input string tag, input logic [7:0] got,
                          input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h at %0t", lane, tag, got, exp, $time);
    end
  endtask

  task automatic check_rst(input int lane, input logic [4:0] ctl, input logic [7:0] madr,
                           input logic [7:0] mwd, input logic [7:0] rd0, input logic [7:0] rd1);
    check_eq(lane, "rst_ctl", {3'b000, ctl}, 8'h00);
    check_eq(lane, "rst_mem_adr", madr, 8'h00);
    check_eq(lane, "rst_mem_wdata", mwd, 8'h00);
    check_eq(lane, "rst_p0_rdata", rd0, 8'h00);
    check_eq(lane, "rst_p1_rdata", rd1, 8'h00);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned Lat = (g == 0) ? 1 : 3;

    logic       rst;
    logic       req [2];
    logic       we  [2];
    logic [7:0] adr [2];
    logic [7:0] wd  [2];
    logic       ack0, ack1, mem_read, mem_write, busy;
    logic [7:0] rdata0, rdata1, mem_adr, mem_wdata, mem_rdata;

    mem_arbiter #(.WIDTH(8), .MEMLAT(Lat)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .p0_req    (req[0]),
      .p0_we     (we[0]),
      .p0_adr    (adr[0]),
      .p0_wdata  (wd[0]),
      .p0_ack    (ack0),
      .p0_rdata  (rdata0),
      .p1_req    (req[1]),
      .p1_we     (we[1]),
      .p1_adr    (adr[1]),
      .p1_wdata  (wd[1]),
      .p1_ack    (ack1),
      .p1_rdata  (rdata1),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    logic [7:0] mem  [256];
    slot_t      ring [32];
    logic       mr_v [32];
    logic [7:0] mr_d [32];
    int         cyc, m_free, n_acks, phase, ph_cyc, guard;
    logic       m_last, m_gnt;
    logic [7:0] m_adr, m_wd, m_rd0, m_rd1;
    bit         done = 1'b0;

    initial begin : drive
      slot_t s;
      logic  a [2];
      logic  gs;
      int    st, ak;

      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[p] = 1'b0; we[p] = 1'b0; adr[p] = 8'h00; wd[p] = 8'h00;
      end
      mem_rdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h40] = 8'h3C;
      for (int k = 0; k < 32; k++) begin
        ring[k] = '0; mr_v[k] = 1'b0; mr_d[k] = 8'h00;
      end
      m_last = 1'b1; m_gnt = 1'b0;
      m_adr = 8'h00; m_wd = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
      phase = 0; ph_cyc = 0; n_acks = 0; cyc = 0; guard = 0;

      repeat (3) @(negedge clk);
      check_rst(g, {ack0, ack1, mem_read, mem_write, busy}, mem_adr, mem_wdata, rdata0, rdata1);
      rst = 1'b0;
      m_free = 0;
      req[0] = 1'b1; we[0] = 1'b1; adr[0] = 8'h12; wd[0] = 8'hA5;

      while (phase != 6 && guard < 4000) begin
        // Grant decision for inputs present in this cycle.
        if (cyc >= m_free && (req[0] || req[1])) begin
          gs     = (req[0] && req[1]) ? ~m_last : req[1];
          m_last = gs;
          m_gnt  = gs;
          m_adr  = adr[gs];
          m_wd   = wd[gs];
          st     = cyc + 1;
          ak     = we[gs] ? st + 1 : st + 1 + int'(Lat);
          ring[st % 32].rd = ~we[gs];
          ring[st % 32].wr = we[gs];
          for (int k = st; k <= ak; k++) ring[k % 32].busy = 1'b1;
          if (!we[gs]) begin
            for (int k = st + 1; k <= st + int'(Lat); k++) ring[k % 32].wt = 1'b1;
            ring[ak % 32].rdv = 1'b1;
            ring[ak % 32].rdp = gs;
            ring[ak % 32].rdd = mem[adr[gs]];
          end
          if (gs) ring[ak % 32].ack1 = 1'b1;
          else    ring[ak % 32].ack0 = 1'b1;
          m_free = ak + 1;
        end

        @(negedge clk);
        cyc++;
        guard++;

        s = ring[cyc % 32];
        ring[cyc % 32] = '0;
        if (s.rdv) begin
          if (s.rdp) m_rd1 = s.rdd;
          else       m_rd0 = s.rdd;
        end
        check_eq(g, "p0_ack", 8'(ack0), 8'(s.ack0));
        check_eq(g, "p1_ack", 8'(ack1), 8'(s.ack1));
        check_eq(g, "mem_read", 8'(mem_read), 8'(s.rd));
        check_eq(g, "mem_write", 8'(mem_write), 8'(s.wr));
        check_eq(g, "busy", 8'(busy), 8'(s.busy));
        check_eq(g, "mem_adr", mem_adr, m_adr);
        check_eq(g, "mem_wdata", mem_wdata, m_wd);
        check_eq(g, "p0_rdata", rdata0, m_rd0);
        check_eq(g, "p1_rdata", rdata1, m_rd1);

        // Memory: data valid only in the cycle Lat after the strobe, junk otherwise.
        if (mem_write) mem[mem_adr] = mem_wdata;
        if (mem_read) begin
          mr_v[(cyc + int'(Lat)) % 32] = 1'b1;
          mr_d[(cyc + int'(Lat)) % 32] = mem[mem_adr];
        end
        mem_rdata = mr_v[cyc % 32] ? mr_d[cyc % 32] : 8'($urandom);
        mr_v[cyc % 32] = 1'b0;

        a[0] = s.ack0;
        a[1] = s.ack1;

        if (phase == 4 && s.wt && !m_gnt) begin
          rst = 1'b1;
          #1;
          check_rst(g, {ack0, ack1, mem_read, mem_write, busy}, mem_adr, mem_wdata, rdata0,
                    rdata1);
          @(negedge clk);
          cyc++;
          rst = 1'b0;
          for (int k = 0; k < 32; k++) begin
            ring[k] = '0; mr_v[k] = 1'b0;
          end
          m_last = 1'b1; m_adr = 8'h00; m_wd = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
          m_free = cyc;
          for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; we[p] = 1'($urandom_range(0, 1));
            adr[p] = 8'($urandom); wd[p] = 8'($urandom);
          end
          phase  = 5;
          n_acks = 0;
        end else begin
          case (phase)
            0: if (a[0]) begin
              req[0] = 1'b0;
              req[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h40; wd[1] = 8'($urandom);
              phase = 1;
            end
            1: if (a[1]) begin
              check_eq(g, "read_p1_rdata", rdata1, 8'h3C);
              check_eq(g, "read_p0_rdata_kept", rdata0, 8'h00);
              for (int p = 0; p < 2; p++) begin
                req[p] = 1'b1; we[p] = 1'($urandom_range(0, 1));
                adr[p] = 8'($urandom); wd[p] = 8'($urandom);
              end
              phase  = 2;
              n_acks = 0;
            end
            2: begin
              for (int p = 0; p < 2; p++) begin
                if (a[p]) begin
                  n_acks++;
                  we[p] = 1'($urandom_range(0, 1)); adr[p] = 8'($urandom); wd[p] = 8'($urandom);
                end
              end
              if (n_acks >= 8) begin
                phase  = 3;
                ph_cyc = 0;
              end
            end
            3: begin
              for (int p = 0; p < 2; p++) begin
                if (a[p] || (!req[p] && $urandom_range(0, 2) == 0)) begin
                  req[p] = 1'($urandom_range(0, 1)) | ~a[p];
                  we[p]  = 1'($urandom_range(0, 1));
                  adr[p] = 8'($urandom); wd[p] = 8'($urandom);
                end else if (req[p] && $urandom_range(0, 31) == 0) begin
                  req[p] = 1'b0;
                end
              end
              ph_cyc++;
              if (ph_cyc > 300) phase = 4;
            end
            4: begin
              for (int p = 0; p < 2; p++) begin
                if (a[p] || !req[p]) begin
                  req[p] = 1'b1; we[p] = 1'b0; adr[p] = 8'($urandom); wd[p] = 8'($urandom);
                end
              end
            end
            5: begin
              if (n_acks == 0 && (a[0] || a[1])) check_eq(g, "tie_after_rst_p0", 8'(ack0), 8'h01);
              for (int p = 0; p < 2; p++) begin
                if (a[p]) begin
                  n_acks++;
                  we[p] = 1'($urandom_range(0, 1)); adr[p] = 8'($urandom); wd[p] = 8'($urandom);
                end
              end
              if (n_acks >= 6) phase = 6;
            end
            default: ;
          endcase
        end
      end

      check_eq(g, "all_phases_done", 8'(phase), 8'd6);
      req[0] = 1'b0;
      req[1] = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    wait (g_lane[0].done && g_lane[1].done);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
